// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the shift-register sequencer: FSM encoding, default
// handshake timing and the wait-counter sizing rule.
package shift_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SAVE_REQ,
        ST_SHIFT_REQ,
        ST_DROP,
        ST_CAPTURE,
        ST_RESP
    } state_e;

    localparam int SETTLE_DEF  = 2;
    localparam int TIMEOUT_DEF = 15;

    // The wait counter only has to reach TIMEOUT-1 before the abort fires.
    function automatic int wait_cnt_w(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

    localparam int WAIT_W_DEF = wait_cnt_w(TIMEOUT_DEF);

endpackage

// File: rtl/shift_seq_ctrl_sync_2ff.sv
// Two-flop synchronizer for the self-timed register's finish levels.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer driving an asynchronous left-shift register: one save, then N
// shift handshakes, then returns the register contents over valid/ready.
module shift_seq_ctrl
    import shift_seq_ctrl_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int SETTLE  = SETTLE_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [WIDTH-1:0]   cmd_data,
    input  logic [SHAMT_W-1:0] cmd_shamt,
    output logic [WIDTH-1:0]   reg_in,
    output logic               save_req,
    input  logic               save_fin,
    output logic               left_req,
    input  logic               left_fin,
    input  logic [WIDTH-1:0]   reg_out,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               rsp_err,
    output logic               busy
);

    localparam int                WAIT_W      = wait_cnt_w(TIMEOUT);
    localparam logic [WAIT_W-1:0] SETTLE_LAST = WAIT_W'(SETTLE - 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_LAST = WAIT_W'(TIMEOUT - 1);

    state_e             state_q;
    logic [SHAMT_W-1:0] rem_q;
    logic [WAIT_W-1:0]  wcnt_q;
    logic [WIDTH-1:0]   reg_in_q;
    logic [WIDTH-1:0]   rsp_data_q;
    logic               save_req_q;
    logic               left_req_q;
    logic               cmd_ready_q;
    logic               rsp_valid_q;
    logic               rsp_err_q;
    logic               busy_q;

    logic save_fin_s;
    logic left_fin_s;
    logic fin_s;

    sync_2ff u_sync_save (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (save_fin),
        .q_o   (save_fin_s)
    );

    sync_2ff u_sync_left (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (left_fin),
        .q_o   (left_fin_s)
    );

    assign fin_s = (state_q == ST_SAVE_REQ) ? save_fin_s : left_fin_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            wcnt_q      <= '0;
            reg_in_q    <= '0;
            rsp_data_q  <= '0;
            save_req_q  <= 1'b0;
            left_req_q  <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        reg_in_q    <= cmd_data;
                        rem_q       <= cmd_shamt;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_SETUP;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    save_req_q <= 1'b1;
                    wcnt_q     <= '0;
                    state_q    <= ST_SAVE_REQ;
                end
                // fin is trusted only once the synchronizer has had SETTLE cycles
                ST_SAVE_REQ, ST_SHIFT_REQ: begin
                    if (wcnt_q >= SETTLE_LAST && fin_s) begin
                        save_req_q <= 1'b0;
                        left_req_q <= 1'b0;
                        state_q    <= ST_DROP;
                    end else if (wcnt_q == TIMEOUT_LAST) begin
                        save_req_q  <= 1'b0;
                        left_req_q  <= 1'b0;
                        rsp_err_q   <= 1'b1;
                        rsp_data_q  <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        wcnt_q <= wcnt_q + WAIT_W'(1);
                    end
                end
                ST_DROP: begin
                    if (rem_q != '0) begin
                        rem_q      <= rem_q - SHAMT_W'(1);
                        left_req_q <= 1'b1;
                        wcnt_q     <= '0;
                        state_q    <= ST_SHIFT_REQ;
                    end else begin
                        state_q <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    rsp_data_q  <= reg_out;
                    rsp_err_q   <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign reg_in    = reg_in_q;
    assign save_req  = save_req_q;
    assign left_req  = left_req_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a behavioural self-timed shift register.
module tb_shift_seq_ctrl;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;
    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 15;

    logic               clk       = 1'b0;
    logic               rst_n     = 1'b0;
    logic               cmd_valid = 1'b0;
    logic [WIDTH-1:0]   cmd_data  = '0;
    logic [SHAMT_W-1:0] cmd_shamt = '0;
    logic               rsp_ready = 1'b0;
    logic               cmd_ready;
    logic [WIDTH-1:0]   reg_in;
    logic               save_req;
    logic               left_req;
    logic               rsp_valid;
    logic [WIDTH-1:0]   rsp_data;
    logic               rsp_err;
    logic               busy;

    logic             save_fin_raw = 1'b1;
    logic             save_dead    = 1'b0;
    logic             left_fin     = 1'b1;
    logic             save_fin;
    logic [WIDTH-1:0] model_reg    = '0;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int nsave   = 0;
    int nleft   = 0;
    int acc_cyc = 0;

    logic [WIDTH-1:0] m_data  = '0;
    logic             m_err   = 1'b0;
    int               m_shamt = 0;

    assign save_fin = save_fin_raw & ~save_dead;

    shift_seq_ctrl #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W),
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_shamt (cmd_shamt),
        .reg_in    (reg_in),
        .save_req  (save_req),
        .save_fin  (save_fin),
        .left_req  (left_req),
        .left_fin  (left_fin),
        .reg_out   (model_reg),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Self-timed register: fin drops at req rise and returns 3 ns later.
    always @(posedge save_req or posedge left_req) begin
        if (save_req) begin
            nsave = nsave + 1;
            save_fin_raw = 1'b0;
            #3;
            if (!save_dead) model_reg = reg_in;
            save_fin_raw = 1'b1;
        end else begin
            nleft = nleft + 1;
            left_fin = 1'b0;
            #3;
            model_reg = {model_reg[WIDTH-2:0], 1'b0};
            left_fin = 1'b1;
        end
    end

    function automatic logic [WIDTH-1:0] model_result(input logic [WIDTH-1:0] d, input int sh);
        return d << sh;
    endfunction

    function automatic int model_latency(input int sh);
        return 2 + (sh + 1) * (SETTLE + 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic pv = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
                continue;
            end
            check("mdl_req_exclusive", 32'(save_req & left_req), 32'd0);
            if (rsp_valid) begin
                check("mdl_rsp_data", rsp_data, m_data);
                check("mdl_rsp_err", 32'(rsp_err), 32'(m_err));
                check("mdl_busy_in_resp", 32'(busy), 32'd1);
                check("mdl_reqs_low_in_resp", 32'({save_req, left_req}), 32'd0);
                if (!pv && !m_err)
                    check("mdl_latency", cyc - acc_cyc, model_latency(m_shamt));
            end
            pv = rsp_valid;
        end
    endtask

    task automatic do_cmd(input logic [WIDTH-1:0] d, input logic [SHAMT_W-1:0] sh,
                          input logic dead, input int hold, input logic [WIDTH-1:0] exp_d,
                          input logic exp_e, input int exp_lat, input int exp_left,
                          input string tag);
        int n;
        int s0;
        int l0;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        m_data    = dead ? '0 : model_result(d, int'(sh));
        m_err     = dead;
        m_shamt   = int'(sh);
        cmd_valid = 1'b1;
        cmd_data  = d;
        cmd_shamt = sh;
        s0 = nsave;
        l0 = nleft;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        check({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
        check({tag, "_ready_low_after_accept"}, 32'(cmd_ready), 32'd0);
        if (hold == 0) begin
            cmd_valid = 1'b0;
        end else begin
            cmd_data  = 32'h3;
            cmd_shamt = 5'd1;
        end
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_rsp_data"}, rsp_data, exp_d);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'(exp_e));
        if (exp_lat >= 0) check({tag, "_latency"}, cyc - acc_cyc, exp_lat);
        check({tag, "_save_rises"}, nsave - s0, 1);
        check({tag, "_left_rises"}, nleft - l0, exp_left);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, "_hold_data"}, rsp_data, exp_d);
            check({tag, "_hold_ready_low"}, 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({tag, "_rsp_cleared"}, 32'(rsp_valid), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int n;
        int l0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check("rst_save_req", 32'(save_req), 32'd0);
        check("rst_left_req", 32'(left_req), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_reg_in", reg_in, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_first_idle", 32'(cmd_ready), 32'd1);

        do_cmd(32'h0000_00F1, 5'd4, 1'b0, 0, 32'h0000_0F10, 1'b0, 17, 4, "shamt4");
        do_cmd(32'hA5A5_A5A5, 5'd0, 1'b0, 0, 32'hA5A5_A5A5, 1'b0, 5, 0, "shamt0");
        do_cmd(32'h8000_0001, 5'd1, 1'b0, 0, 32'h0000_0002, 1'b0, 8, 1, "msb_out");

        save_dead = 1'b1;
        repeat (4) @(negedge clk);
        do_cmd(32'h1234_5678, 5'd3, 1'b1, 0, 32'h0, 1'b1, -1, 0, "timeout");
        save_dead = 1'b0;
        repeat (4) @(negedge clk);

        do_cmd(32'h0000_000F, 5'd2, 1'b0, 5, 32'h0000_003C, 1'b0, 11, 2, "rsp_hold");
        do_cmd(32'h0000_0003, 5'd1, 1'b0, 0, 32'h0000_0006, 1'b0, 8, 1, "second_cmd");

        // Abort during the second shift of a four-shift command.
        @(negedge clk);
        m_data    = model_result(32'h0000_00F1, 4);
        m_err     = 1'b0;
        m_shamt   = 4;
        cmd_valid = 1'b1;
        cmd_data  = 32'h0000_00F1;
        cmd_shamt = 5'd4;
        l0 = nleft;
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        cmd_valid = 1'b0;
        n = 0;
        while (nleft - l0 < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("midrst_second_shift_seen", nleft - l0, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_save_req", 32'(save_req), 32'd0);
        check("midrst_left_req", 32'(left_req), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_rsp_data", rsp_data, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_cmd(32'h0000_0001, 5'd2, 1'b0, 0, 32'h0000_0004, 1'b0, 11, 2, "after_rst");

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
